// File: rtl/vdf_sq_loop_ctrl.sv
// Repeated-squaring sequencer for the VDF: feeds each squarer result back as the next operand T times.
// Optional checkpoint outputs are compiled in with `define VDF_SQ_CHECKPOINT_EN.
module vdf_sq_loop_ctrl #(
    parameter int WORD_BITS       = 32,
    parameter int NUM_WORDS       = 32,
    parameter int REDUN_WORD_BITS = 1,
    parameter int I_WORD          = NUM_WORDS + 1,
    parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
    parameter int ITER_BITS       = 64,
    parameter int TIMEOUT_CYCLES  = 4096
`ifdef VDF_SQ_CHECKPOINT_EN
    ,
    parameter int CHK_SHIFT       = 20
`endif
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start_val,
    output logic                                o_start_rdy,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]    i_start_dat,
    input  logic [ITER_BITS-1:0]                i_start_iter,
    input  logic                                i_abort,
    output logic                                o_sq_val,
    output logic [I_WORD-1:0][COEF_BITS-1:0]    o_sq_dat,
    input  logic                                i_sq_val,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]    i_sq_dat,
    output logic                                o_res_val,
    input  logic                                i_res_rdy,
    output logic [I_WORD-1:0][COEF_BITS-1:0]    o_res_dat,
    output logic [ITER_BITS-1:0]                o_res_iter,
`ifdef VDF_SQ_CHECKPOINT_EN
    output logic                                o_chk_val,
    output logic [I_WORD-1:0][COEF_BITS-1:0]    o_chk_dat,
    output logic [ITER_BITS-1:0]                o_chk_iter,
`endif
    output logic                                o_busy,
    output logic                                o_err
);

    localparam int TMO_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]                          state;
    logic [I_WORD-1:0][COEF_BITS-1:0]    operand;
    logic [ITER_BITS-1:0]                remaining;
    logic [ITER_BITS-1:0]                done_cnt;
    logic [TMO_BITS-1:0]                 tmo_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            // NOTE: the operand register is reset too, so o_sq_dat/o_res_dat read 0 after reset.
            operand   <= '0;
            remaining <= '0;
            done_cnt  <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start_val) begin
                        operand   <= i_start_dat;
                        remaining <= i_start_iter;
                        done_cnt  <= '0;
                        state     <= (i_start_iter == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= i_abort ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (i_sq_val) begin
                        // A result landing with the abort leaves nothing in flight, so skip DRAIN.
                        if (i_abort) begin
                            state <= S_IDLE;
                        end else begin
                            operand   <= i_sq_dat;
                            remaining <= remaining - ITER_BITS'(1);
                            done_cnt  <= done_cnt + ITER_BITS'(1);
                            state     <= (remaining == ITER_BITS'(1)) ? S_DONE : S_ISSUE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_BITS'(1);
                        if (i_abort) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_sq_val) begin
                        state <= S_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_BITS'(1);
                    end
                end
                S_DONE: begin
                    if (i_res_rdy) state <= S_IDLE;
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: outputs are continuous decodes of registered state; no combinational process, no latch risk.
    assign o_start_rdy = (state == S_IDLE);
    assign o_busy      = (state != S_IDLE);
    assign o_err       = (state == S_ERR);
    assign o_sq_val    = (state == S_ISSUE) && !i_abort;
    assign o_sq_dat    = operand;
    assign o_res_val   = (state == S_DONE);
    assign o_res_dat   = operand;
    assign o_res_iter  = done_cnt;

`ifdef VDF_SQ_CHECKPOINT_EN
    logic                 capture;
    logic [ITER_BITS-1:0] done_next;

    assign capture   = (state == S_WAIT) && i_sq_val && !i_abort;
    assign done_next = done_cnt + ITER_BITS'(1);

    // Final iteration (remaining==1) is reported on the result port, not as a checkpoint.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_chk_val  <= 1'b0;
            o_chk_dat  <= '0;
            o_chk_iter <= '0;
        end else begin
            o_chk_val <= capture && (done_next[CHK_SHIFT-1:0] == '0)
                         && (remaining != ITER_BITS'(1));
            if (capture) begin
                o_chk_dat  <= i_sq_dat;
                o_chk_iter <= done_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vdf_sq_loop_ctrl.sv
// Self-checking bench for vdf_sq_loop_ctrl: behavioural squarer (x^2 mod 2^31-1, latency 10) and result scoreboard.
// Checkpoint checks are compiled in with `define VDF_SQ_CHECKPOINT_EN.
module tb_vdf_sq_loop_ctrl;

    localparam int I_WORD    = 33;
    localparam int COEF_BITS = 33;
    localparam int ITER_BITS = 64;
    localparam int BW        = I_WORD * COEF_BITS;
    localparam int TMO       = 16;
    localparam int L         = 10;
    localparam longint unsigned MODULUS = 64'd2147483647;

    typedef logic [I_WORD-1:0][COEF_BITS-1:0] bus_t;
    typedef struct {
        logic [BW-1:0]        dat;
        logic [ITER_BITS-1:0] iter;
        int                   cyc;
    } exp_t;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_start_val = 1'b0;
    logic                 o_start_rdy;
    bus_t                 i_start_dat = '0;
    logic [ITER_BITS-1:0] i_start_iter = '0;
    logic                 i_abort = 1'b0;
    logic                 o_sq_val;
    bus_t                 o_sq_dat;
    logic                 i_sq_val = 1'b0;
    bus_t                 i_sq_dat = '0;
    logic                 o_res_val;
    logic                 i_res_rdy = 1'b1;
    bus_t                 o_res_dat;
    logic [ITER_BITS-1:0] o_res_iter;
    logic                 o_busy;
    logic                 o_err;
`ifdef VDF_SQ_CHECKPOINT_EN
    logic                 o_chk_val;
    bus_t                 o_chk_dat;
    logic [ITER_BITS-1:0] o_chk_iter;
`endif

    vdf_sq_loop_ctrl #(
        .TIMEOUT_CYCLES (TMO)
`ifdef VDF_SQ_CHECKPOINT_EN
        ,
        .CHK_SHIFT      (2)
`endif
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start_val  (i_start_val),
        .o_start_rdy  (o_start_rdy),
        .i_start_dat  (i_start_dat),
        .i_start_iter (i_start_iter),
        .i_abort      (i_abort),
        .o_sq_val     (o_sq_val),
        .o_sq_dat     (o_sq_dat),
        .i_sq_val     (i_sq_val),
        .i_sq_dat     (i_sq_dat),
        .o_res_val    (o_res_val),
        .i_res_rdy    (i_res_rdy),
        .o_res_dat    (o_res_dat),
        .o_res_iter   (o_res_iter),
`ifdef VDF_SQ_CHECKPOINT_EN
        .o_chk_val    (o_chk_val),
        .o_chk_dat    (o_chk_dat),
        .o_chk_iter   (o_chk_iter),
`endif
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc  = 0;
    int sq_issues  = 0;
    int issue_base = 0;
    int drop_at    = 0;
    int stray_req  = 0;
    int res_count  = 0;
    exp_t sb[$];
    exp_t chk_q[$];

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned sq_mod(input longint unsigned v);
        return (v * v) % MODULUS;
    endfunction

    function automatic longint unsigned pow2k(input longint unsigned x, input int k);
        longint unsigned r = x;
        for (int i = 0; i < k; i++) r = sq_mod(r);
        return r;
    endfunction

    function automatic bus_t pack(input longint unsigned v);
        bus_t b = '0;
        b[0] = {1'b0, v[31:0]};
        b[1] = {1'b0, v[63:32]};
        return b;
    endfunction

    function automatic longint unsigned unpack(input bus_t b);
        return 64'(b[0]) + (64'(b[1]) << 32);
    endfunction

    initial forever begin
        @(posedge i_clk);
        cyc = cyc + 1;
    end

    // Squarer model: answers each issue L cycles later unless told to drop it; can inject stray pulses.
    initial begin
        bit              pend = 1'b0;
        int              cd = 0;
        int              stray_done = 0;
        longint unsigned pend_val = 0;
        forever begin
            @(negedge i_clk);
            i_sq_val = 1'b0;
            if (i_rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cd--;
                    if (cd == 0) begin
                        i_sq_val = 1'b1;
                        i_sq_dat = pack(pend_val);
                        pend     = 1'b0;
                    end
                end
                if (stray_req != stray_done) begin
                    stray_done = stray_req;
                    i_sq_val   = 1'b1;
                    i_sq_dat   = pack(64'h1234_5678);
                end
                if (o_sq_val) begin
                    sq_issues++;
                    check("sq_cyc", BW'(cyc - start_cyc), BW'(1 + (sq_issues - issue_base - 1) * (L + 1)));
                    check("sq_single_inflight", BW'(pend), BW'(0));
                    if (sq_issues != drop_at) begin
                        pend     = 1'b1;
                        cd       = L;
                        pend_val = sq_mod(unpack(o_sq_dat));
                    end
                end
            end
        end
    end

    // Result monitor: every rising o_res_val must match the head of the scoreboard.
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_res_val && !prev) begin
                res_count++;
                check("res_expected", BW'(sb.size() != 0), BW'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("res_dat", o_res_dat, e.dat);
                    check("res_iter", BW'(o_res_iter), BW'(e.iter));
                    check("res_cyc", BW'(cyc - start_cyc), BW'(e.cyc));
                end
            end
            prev = o_res_val;
        end
    end

`ifdef VDF_SQ_CHECKPOINT_EN
    int chk_count = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_chk_val) begin
                chk_count++;
                check("chk_expected", BW'(chk_q.size() != 0), BW'(1));
                if (chk_q.size() != 0) begin
                    e = chk_q.pop_front();
                    check("chk_dat", o_chk_dat, e.dat);
                    check("chk_iter", BW'(o_chk_iter), BW'(e.iter));
                end
            end
        end
    end
`endif

    task automatic start_run(input longint unsigned x, input int t, input bit push);
        exp_t e;
        int   i = 0;
        while (!o_start_rdy && i < 300) begin
            @(negedge i_clk);
            i++;
        end
        if (!o_start_rdy) begin
            check("start_rdy_timeout", BW'(o_start_rdy), BW'(1));
            return;
        end
        i_start_dat  = pack(x);
        i_start_iter = ITER_BITS'(t);
        i_start_val  = 1'b1;
        start_cyc    = cyc;
        issue_base   = sq_issues;
        if (push) begin
            e.dat  = pack(pow2k(x, t));
            e.iter = ITER_BITS'(t);
            e.cyc  = t * (L + 1) + 1;
            sb.push_back(e);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_start_val = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (o_busy && i < budget) begin
            @(negedge i_clk);
            i++;
        end
        check("idle_reached", BW'(o_busy), BW'(0));
    endtask

    initial begin
        exp_t e;
        int   n;
        int   err_rel;

        // Reset values
        repeat (3) @(negedge i_clk);
        check("rst_start_rdy", BW'(o_start_rdy), BW'(1));
        check("rst_busy", BW'(o_busy), BW'(0));
        check("rst_err", BW'(o_err), BW'(0));
        check("rst_sq_val", BW'(o_sq_val), BW'(0));
        check("rst_res_val", BW'(o_res_val), BW'(0));
        check("rst_res_dat", o_res_dat, BW'(0));
        check("rst_res_iter", BW'(o_res_iter), BW'(0));
        i_rst = 1'b0;
        @(negedge i_clk);

        // x=3, T=4: 3^16 = 43046721 at cycle 45 with four issues
        e.dat = pack(64'd43046721); e.iter = 64'd4; e.cyc = 45;
        i_res_rdy = 1'b1;
        start_run(3, 4, 1'b0);
        sb.push_back(e);
        wait_idle(200);
        check("t4_issue_count", BW'(sq_issues - issue_base), BW'(4));

        // T=0 with the consumer stalled; a stray squarer pulse during DONE must not disturb the result
        i_res_rdy = 1'b0;
        start_run(7, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) stray_req++;
            check("t0_res_val_held", BW'(o_res_val), BW'(1));
            check("t0_res_dat_stable", o_res_dat, pack(64'd7));
            check("t0_start_rdy", BW'(o_start_rdy), BW'(0));
            @(negedge i_clk);
        end
        check("t0_issue_count", BW'(sq_issues - issue_base), BW'(0));
        i_res_rdy = 1'b1;
        @(negedge i_clk);
        check("t0_res_val_drop", BW'(o_res_val), BW'(0));
        check("t0_back_idle", BW'(o_start_rdy), BW'(1));

        // Squarer drops the second issue: ERR 16 cycles after WAIT entry, left only by reset
        drop_at = sq_issues + 2;
        start_run(5, 5, 1'b0);
        n = 0;
        while (!o_err && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        err_rel = cyc - start_cyc;
        check("tmo_err_set", BW'(o_err), BW'(1));
        check("tmo_err_cycle", BW'(err_rel), BW'(1 + (L + 1) + 1 + TMO));
        check("tmo_start_rdy", BW'(o_start_rdy), BW'(0));
        i_start_val = 1'b1;
        repeat (3) @(negedge i_clk);
        i_start_val = 1'b0;
        check("tmo_err_sticky", BW'(o_err), BW'(1));
        i_rst = 1'b1;
        @(negedge i_clk);
        check("tmo_rst_err", BW'(o_err), BW'(0));
        check("tmo_rst_start_rdy", BW'(o_start_rdy), BW'(1));
        i_rst = 1'b0;
        drop_at = 0;
        @(negedge i_clk);

        // Abort during the third WAIT: late result discarded, no result, then a clean new run
        n = res_count;
        start_run(7, 100, 1'b0);
        for (int k = 0; k < 500 && (sq_issues - issue_base) < 3; k++) @(negedge i_clk);
        repeat (2) @(negedge i_clk);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_drain_busy", BW'(o_busy), BW'(1));
        wait_idle(100);
        repeat (L + 2) @(negedge i_clk);
        check("abort_issue_count", BW'(sq_issues - issue_base), BW'(3));
        check("abort_no_result", BW'(res_count), BW'(n));
        check("abort_start_rdy", BW'(o_start_rdy), BW'(1));
        e.dat = pack(64'd256); e.iter = 64'd3; e.cyc = 34;
        start_run(2, 3, 1'b0);
        sb.push_back(e);
        wait_idle(200);

        // Stray pulse in IDLE, then back-to-back runs with the consumer always ready
        stray_req++;
        repeat (2) @(negedge i_clk);
        check("stray_idle_busy", BW'(o_busy), BW'(0));
        check("stray_idle_rdy", BW'(o_start_rdy), BW'(1));
        start_run(3, 2, 1'b1);
        start_run(11, 3, 1'b1);
        start_run(12345, 5, 1'b1);
        start_run(9, 0, 1'b1);
        start_run(1000003, 1, 1'b1);
        wait_idle(300);

`ifdef VDF_SQ_CHECKPOINT_EN
        // Checkpoints every 4 iterations of a 10-iteration run: at counts 4 and 8 only
        e.dat = pack(pow2k(3, 4)); e.iter = 64'd4; e.cyc = 0;
        chk_q.push_back(e);
        e.dat = pack(pow2k(3, 8)); e.iter = 64'd8;
        chk_q.push_back(e);
        start_run(3, 10, 1'b1);
        wait_idle(300);
        repeat (2) @(negedge i_clk);
        check("chk_count", BW'(chk_count), BW'(2));
        check("chk_queue_empty", BW'(chk_q.size()), BW'(0));
`endif

        repeat (2) @(negedge i_clk);
        check("sb_empty", BW'(sb.size()), BW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
